ram_scan_reader: RTL and testbench

//  Autonomous read-side sequencer for the 32x4 lab RAM (ram32x4).
//  - Walks all 32 addresses; reads each word; holds address/data on display outputs for a dwell period.
//  - Sits beside the switch-driven write path; disp_* feed the existing hex_decoder instances.
//  - Never writes: ram_wren is tied 0.

---
 rtl/ram_scan_pkg.sv | 26 ++
 rtl/ram_scan_reader_dwell_counter.sv | 40 ++++
 rtl/ram_scan_reader.sv | 195 +++++++++++++++++++
 tb/tb_ram_scan_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram_scan_pkg
// Description : Shared constants for the ram_scan_reader read sequencer:
//               default RAM geometry, checksum width and the FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_scan_pkg;

  // Default RAM geometry (32 words x 4 bits)
  localparam int C_ADDR_W = 5;
  localparam int C_DATA_W = 4;

  // Width of the optional pass checksum (modulo 256)
  localparam int C_CHK_W  = 8;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t C_ST_IDLE  = 2'd0;
  localparam state_t C_ST_ISSUE = 2'd1;
  localparam state_t C_ST_WAIT  = 2'd2;
  localparam state_t C_ST_SHOW  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ram_scan_reader_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : dwell_counter
// Description : Loadable down-counter with count enable and zero flag. The
//               counter parks at zero; load has priority over enable.
// Ports       : clock      - system clock, rising edge
//               reset      - asynchronous active-high reset
//               load       - load load_value on the next edge
//               load_value - value to load
//               enable     - decrement when non-zero (pause gate)
//               zero       - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : ram_scan_reader
// Description : Autonomous read-side sequencer for the 32x4 lab RAM. Walks
//               every address, captures each word and holds address/data on
//               the display outputs for DWELL_CYCLES cycles. Never writes.
// Ports       : clock, reset (async, active-high)
//               start       - begin a pass (sampled in IDLE only)
//               continuous  - wrap last->0 instead of stopping
//               pause       - freeze the dwell countdown
//               ram_address / ram_wren (tied 0) / ram_q - RAM read port
//               disp_addr / disp_data / disp_valid - displayed word
//               busy        - not idle
//               done        - one-cycle pulse at end of a stopping pass
//               checksum    - sum of last completed pass (SCAN_CHECKSUM_EN)
// Config      : define SCAN_CHECKSUM_EN to build the pass checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W       = C_ADDR_W,
  parameter int DATA_W       = C_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int DWELL_CYCLES = 25_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              pause,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
`ifdef SCAN_CHECKSUM_EN
  ,
  output logic [C_CHK_W-1:0] checksum
`endif
);

  localparam int                c_dw_w       = $clog2(DWELL_CYCLES + 1);
  localparam int                c_lat_w      = $clog2(RD_LAT + 1);
  localparam logic [c_dw_w-1:0]  c_dwell_load = c_dw_w'(DWELL_CYCLES - 1);
  localparam logic [c_lat_w-1:0] c_lat_load   = c_lat_w'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0]  c_last_addr  = {ADDR_W{1'b1}};

  state_t              r_state,      w_state_next;
  logic [ADDR_W-1:0]   r_addr,       w_addr_next;
  logic [c_lat_w-1:0]  r_lat,        w_lat_next;
  logic [ADDR_W-1:0]   r_disp_addr,  w_disp_addr_next;
  logic [DATA_W-1:0]   r_disp_data,  w_disp_data_next;
  logic                r_disp_valid, w_disp_valid_next;
  logic                r_done,       w_done_next;

  logic w_dwell_load;
  logic w_dwell_en;
  logic w_dwell_zero;
  logic w_capture;   // read latency has elapsed; ram_q belongs to r_addr
  logic w_word_end;  // dwell expired with pause low; leave current word

  dwell_counter #(
    .WIDTH (c_dw_w)
  ) u_dwell (
    .clock      (clock),
    .reset      (reset),
    .load       (w_dwell_load),
    .load_value (c_dwell_load),
    .enable     (w_dwell_en),
    .zero       (w_dwell_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= C_ST_IDLE;
      r_addr       <= '0;
      r_lat        <= '0;
      r_disp_addr  <= '0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_lat        <= w_lat_next;
      r_disp_addr  <= w_disp_addr_next;
      r_disp_data  <= w_disp_data_next;
      r_disp_valid <= w_disp_valid_next;
      r_done       <= w_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_lat_next        = r_lat;
    w_disp_addr_next  = r_disp_addr;
    w_disp_data_next  = r_disp_data;
    w_disp_valid_next = r_disp_valid;
    w_done_next       = 1'b0;
    w_dwell_load      = 1'b0;
    w_dwell_en        = 1'b0;
    w_capture         = (r_state == C_ST_WAIT) && (r_lat == '0);
    w_word_end        = (r_state == C_ST_SHOW) && w_dwell_zero && !pause;

    case (r_state)
      C_ST_IDLE: begin
        if (start) begin
          w_state_next      = C_ST_ISSUE;
          w_addr_next       = '0;
          w_disp_valid_next = 1'b0;
        end
      end

      // One cycle for ram_address to settle before the RAM registers it.
      C_ST_ISSUE: begin
        w_lat_next   = c_lat_load;
        w_state_next = C_ST_WAIT;
      end

      C_ST_WAIT: begin
        if (w_capture) begin
          w_disp_addr_next  = r_addr;
          w_disp_data_next  = ram_q;
          w_disp_valid_next = 1'b1;
          w_dwell_load      = 1'b1;
          w_state_next      = C_ST_SHOW;
        end else begin
          w_lat_next = r_lat - c_lat_w'(1);
        end
      end

      C_ST_SHOW: begin
        w_dwell_en = !pause;
        if (w_word_end) begin
          if (r_addr != c_last_addr) begin
            w_addr_next  = r_addr + ADDR_W'(1);
            w_state_next = C_ST_ISSUE;
          end else if (continuous) begin
            w_addr_next  = '0;
            w_state_next = C_ST_ISSUE;
          end else begin
            w_done_next  = 1'b1;
            w_state_next = C_ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = C_ST_IDLE;
      end
    endcase
  end

`ifdef SCAN_CHECKSUM_EN
  logic [C_CHK_W-1:0] r_acc;
  logic [C_CHK_W-1:0] r_checksum;

  // The accumulator restarts on the address-0 capture so every pass,
  // including continuous wraps, sums exactly one lap of the RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else begin
      if (w_capture) begin
        if (r_addr == '0) begin
          r_acc <= C_CHK_W'(ram_q);
        end else begin
          r_acc <= r_acc + C_CHK_W'(ram_q);
        end
      end
      if (w_word_end && (r_addr == c_last_addr)) begin
        r_checksum <= r_acc;
      end
    end
  end

  assign checksum = r_checksum;
`endif

  assign ram_address = r_addr;
  assign ram_wren    = 1'b0;
  assign disp_addr   = r_disp_addr;
  assign disp_data   = r_disp_data;
  assign disp_valid  = r_disp_valid;
  assign busy        = (r_state != C_ST_IDLE);
  assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_scan_reader
// Description : Self-checking bench for ram_scan_reader with a behavioural
//               32x4 RAM and a word-period timing model. Define
//               SCAN_CHECKSUM_EN to include the checksum port and checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_scan_reader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int RD_LAT = 1;
  localparam int DWELL  = 4;
  localparam int NWORDS = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic              pause = 1'b0;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              busy;
  logic              done;
`ifdef SCAN_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  ram_scan_reader #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .RD_LAT       (RD_LAT),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .pause       (pause),
    .ram_address (ram_address),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .busy        (busy),
    .done        (done)
`ifdef SCAN_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural RAM: address registered, q combinational from it.
  logic [DATA_W-1:0] mem [NWORDS];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  always @(posedge clock) ram_addr_q <= ram_address;
  assign ram_q = mem[ram_addr_q];

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word lasts 1 + RD_LAT cycles of fetch (ignoring
  // pause) followed by DWELL un-paused display cycles.
  bit m_busy, m_done, m_valid;
  int m_addr, m_t, m_daddr, m_ddata, m_sum, m_checksum;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_valid = 0;
      m_addr = 0; m_t = 0; m_daddr = 0; m_ddata = 0; m_sum = 0; m_checksum = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_addr = 0; m_t = 0; m_valid = 0;
        end
      end else if (m_t < 1 + RD_LAT) begin
        m_t++;
        if (m_t == 1 + RD_LAT) begin
          m_daddr = m_addr;
          m_ddata = int'(mem[m_addr]);
          m_valid = 1;
          m_sum   = (m_addr == 0) ? m_ddata : (m_sum + m_ddata) % 256;
        end
      end else if (!pause) begin
        m_t++;
        if (m_t == 1 + RD_LAT + DWELL) begin
          m_t = 0;
          if (m_addr == NWORDS - 1) begin
            m_checksum = m_sum;
            if (continuous) m_addr = 0;
            else begin
              m_busy = 0; m_done = 1;
            end
          end else begin
            m_addr++;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      chk("ram_address", int'(ram_address), m_addr);
      chk("ram_wren", int'(ram_wren), 0);
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("disp_valid", int'(disp_valid), int'(m_valid));
      chk("disp_addr", int'(disp_addr), m_daddr);
      chk("disp_data", int'(disp_data), m_ddata);
`ifdef SCAN_CHECKSUM_EN
      chk("checksum", int'(checksum), m_checksum);
`endif
    end
  end

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clock);
      k++;
    end
    chk("idle_within_bound", int'(busy), 0);
  endtask

  task automatic fill_mod16();
    for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'(i % 16);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  int cnt, got, dones, hold;

  initial begin
    fill_mod16();

    // 1. reset hold and idle after release
    repeat (3) @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(disp_valid), 0);
    chk("rst_addr", int'(ram_address), 0);
    chk("rst_disp", int'(disp_addr) + int'(disp_data), 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_no_start", int'(busy), 0);

    // 2. single pass, mem[i] = i % 16
    pulse_start();
    cnt = 0; got = -1;
    while (cnt < 400) begin
      if ((cnt % 6 == 2) && (cnt / 6 < NWORDS)) begin
        chk("scan_addr", int'(disp_addr), cnt / 6);
        chk("scan_data", int'(disp_data), (cnt / 6) % 16);
      end
      if (done) begin
        got = cnt;
        break;
      end
      @(negedge clock);
      cnt++;
    end
    chk("done_latency", got, 192);
    chk("done_busy_low", int'(busy), 0);
    @(negedge clock);
    chk("done_one_cycle", int'(done), 0);
    chk("last_word_held", int'(disp_addr), 31);

    // 3. continuous: three full passes, wrap 31 -> 0, no done
    continuous = 1'b1;
    pulse_start();
    dones = 0;
    for (cnt = 0; cnt < 3 * 192 + 10; cnt++) begin
      if (cnt == 188) chk("wrap_last", int'(disp_addr), 31);
      if (cnt == 194) chk("wrap_first", int'(disp_addr), 0);
      if (done) dones++;
      @(negedge clock);
    end
    chk("cont_no_done", dones, 0);
    continuous = 1'b0;
    wait_idle(250);
    @(negedge clock);

    // 4. pause 10 cycles during SHOW of address 5; extra start pulses ignored
    pulse_start();
    cnt = 0; got = -1; hold = 0;
    while (cnt < 400) begin
      pause = (cnt >= 32 && cnt < 42);
      start = (cnt == 50 || cnt == 100);
      if (disp_addr == 5 && ram_address == 5 && disp_valid) hold++;
      if (done) begin
        got = cnt;
        break;
      end
      @(negedge clock);
      cnt++;
    end
    pause = 1'b0; start = 1'b0;
    chk("pause_show_len", hold, 14);
    chk("pause_done_latency", got, 202);
    @(negedge clock);

    // 5. async reset mid-pass, then restart from address 0
    pulse_start();
    cnt = 0;
    while (!(disp_valid && disp_addr == 12) && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    chk("reached_addr12", int'(disp_addr), 12);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(disp_valid), 0);
    chk("arst_addr", int'(ram_address), 0);
    chk("arst_disp", int'(disp_addr) + int'(disp_data), 0);
    chk("arst_done", int'(done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("arst_stays_idle", int'(busy), 0);
    pulse_start();
    chk("restart_addr", int'(ram_address), 0);
    repeat (2) @(negedge clock);
    chk("restart_disp", int'(disp_addr), 0);
    wait_idle(250);

`ifdef SCAN_CHECKSUM_EN
    // 6. checksum over known contents
    for (int i = 0; i < NWORDS; i++) mem[i] = 4'hF;
    @(negedge clock);
    pulse_start();
    wait_idle(250);
    chk("checksum_all_f", int'(checksum), 8'hE0);
    fill_mod16();
    @(negedge clock);
    pulse_start();
    wait_idle(250);
    chk("checksum_mod16", int'(checksum), 8'hF0);
`endif

    // Randomized phases against the model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'($urandom);
      @(negedge clock);
      pulse_start();
      for (int c = 0; c < 300; c++) begin
        pause      = ($urandom % 5 == 0);
        continuous = ($urandom % 3 == 0);
        start      = ($urandom % 7 == 0);
        @(negedge clock);
      end
      pause = 1'b0; continuous = 1'b0; start = 1'b0;
      wait_idle(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
